// File: rtl/dds_phase_accumulator.sv
// DDS phase accumulator: divides the system clock to the sample rate and advances a
// wide phase register by a handshaked frequency tuning word once per sample.
module dds_phase_accumulator #(
   parameter int unsigned ACC_W   = 24,
   parameter int unsigned PHASE_W = 14,
   parameter int unsigned CLK_DIV = 250
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               enable,
   input  logic               phase_sync,
   input  logic [ACC_W-1:0]   ftw_data,
   input  logic               ftw_valid,
   output logic               ftw_ready,
   output logic [PHASE_W-1:0] phase_out,
   output logic               sample_tick,
   output logic               wrap
);

   localparam int unsigned PW = $clog2(CLK_DIV);
   localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

   logic [ACC_W-1:0] acc, acc_d;
   logic [ACC_W-1:0] active_ftw, active_ftw_d;
   logic [ACC_W-1:0] pending_ftw, pending_ftw_d;
   logic             pending_full, pending_full_d;
   logic [PW-1:0]    presc, presc_d;
   logic             sample_tick_d, wrap_d;
   logic             tick, capture, apply;
   logic [ACC_W:0]   sum;

   assign tick      = enable && (presc == PRESC_LAST);
   assign ftw_ready = !pending_full;
   assign capture   = ftw_valid && !pending_full;
   // phase_sync suppresses the apply as well as the accumulate on a tick cycle.
   assign apply     = tick && !phase_sync && pending_full;
   assign sum       = {1'b0, acc} + {1'b0, active_ftw};
   assign phase_out = acc[ACC_W-1 -: PHASE_W];

   always_comb begin
      acc_d          = acc;
      presc_d        = presc;
      sample_tick_d  = 1'b0;
      wrap_d         = 1'b0;
      active_ftw_d   = active_ftw;
      pending_ftw_d  = pending_ftw;
      pending_full_d = pending_full;

      if (phase_sync) begin
         acc_d   = '0;
         presc_d = '0;
      end else if (enable) begin
         presc_d = tick ? '0 : presc + PW'(1);
         if (tick) begin
            acc_d         = sum[ACC_W-1:0];
            wrap_d        = sum[ACC_W];
            sample_tick_d = 1'b1;
         end
      end

      // Capture needs an empty slot and apply needs a full one, so they never collide.
      if (apply) begin
         active_ftw_d   = pending_ftw;
         pending_full_d = 1'b0;
      end
      if (capture) begin
         pending_ftw_d  = ftw_data;
         pending_full_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc          <= '0;
         active_ftw   <= '0;
         pending_ftw  <= '0;
         pending_full <= 1'b0;
         presc        <= '0;
         sample_tick  <= 1'b0;
         wrap         <= 1'b0;
      end else begin
         acc          <= acc_d;
         active_ftw   <= active_ftw_d;
         pending_ftw  <= pending_ftw_d;
         pending_full <= pending_full_d;
         presc        <= presc_d;
         sample_tick  <= sample_tick_d;
         wrap         <= wrap_d;
      end
   end

endmodule

// File: doc/dds_phase_accumulator.md
# dds_phase_accumulator

Phase accumulator for the DDS synthesizer. It feeds the sine lookup stage directly: its `phase_out` drives the lookup's `phase` input. It divides the system clock down to the audio sample rate and advances a wide phase register by a frequency tuning word (FTW) once per sample. New FTWs arrive over a valid/ready handshake and take effect only on a sample boundary.

## Interface
- `ACC_W`, 24, accumulator width in bits.
- `PHASE_W`, 14, output phase width; equals the sine stage input width. `PHASE_W <= ACC_W`.
- `CLK_DIV`, 250, system clocks per sample. Must be ≥ 2. The prescaler is `$clog2(CLK_DIV)` bits wide.

- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  run/hold control for the prescaler and accumulator.
- `phase_sync`  in  1  level-sampled request to zero the phase.
- `ftw_data`  in  ACC_W  new tuning word (unsigned).
- `ftw_valid`  in  1  `ftw_data` is valid.
- `ftw_ready`  out  1  pending slot is empty, so a word can be accepted.
- `phase_out`  out  PHASE_W  top `PHASE_W` bits of the accumulator (`acc[ACC_W-1 -: PHASE_W]`).
- `sample_tick`  out  1  one-cycle pulse, high in the first cycle a new `phase_out` is valid.
- `wrap`  out  1  one-cycle pulse, coincident with `sample_tick` when that update carried out of the MSB.

## Operation
- **Registers:**
  - `acc` (ACC_W)
  - `active_ftw` (ACC_W)
  - `pending_ftw` (ACC_W)
  - `pending_full`
  - `presc`
  - `sample_tick`
  - `wrap`
- **Reset** (`rst` = 1): all registers clear to 0. Resulting outputs: `phase_out` = 0, `sample_tick` = 0, `wrap` = 0, `ftw_ready` = 1.
- **`ftw_ready`:** combinational `!pending_full`, so it is 1 during reset.
- **Prescaler:** while `enable` = 1, `presc` counts 0 .. CLK_DIV-1 and wraps to 0. The internal `tick` is `enable && presc == CLK_DIV-1`. While `enable` = 0, `presc` holds.
- **Accumulate:** on a `tick` cycle, `acc <= acc + active_ftw` modulo 2^ACC_W, using the `active_ftw` value from before this edge. The carry-out is registered into `wrap`.
- **FTW handshake:**
  - Transfer occurs when `ftw_valid && ftw_ready`. `pending_ftw <= ftw_data` and `pending_full <= 1`.
  - The source holds `ftw_data` and `ftw_valid` until the transfer.
- **FTW apply:** on a `tick` cycle with `pending_full` = 1 (pre-edge value), `active_ftw <= pending_ftw` and `pending_full <= 0`. The applied word is first used at the following tick.
- **Same-cycle capture and tick:** if a word is captured (slot empty) in a `tick` cycle, it stays pending and applies at the next tick. Each applied word is used for at least one full sample.
- **`phase_sync`:** in any cycle with `phase_sync` = 1, `acc <= 0`, `presc <= 0`, `sample_tick <= 0`, and `wrap <= 0`. This overrides `tick`, so no accumulate and no FTW apply happen in that cycle. `active_ftw`, `pending_ftw`, `pending_full` and the handshake are unaffected.
- **Priority:** `rst` > `phase_sync` > `tick`.
- **`enable` = 0:** `acc`, `presc` and `active_ftw` hold, and `sample_tick` = 0. The handshake still accepts one word into the pending slot; it waits there for the next tick.
- **Zero FTW:** `active_ftw` = 0 is legal. `phase_out` holds, `sample_tick` still pulses, and `wrap` stays 0.

## Timing
- `tick` occurs on the edge ending the cycle in which `presc` = CLK_DIV-1. `acc` and the registered `sample_tick` update on that same edge.
  - `sample_tick` is therefore high exactly in the first cycle showing the new `phase_out`.
  - The downstream stage samples the LUT output while `sample_tick` = 1.
- **Tick spacing:** exactly CLK_DIV cycles between `sample_tick` pulses while `enable` stays 1 and no `phase_sync` occurs.
- **First tick after reset release or sync:** it lands on the CLK_DIV-th enabled edge after release.
- **FTW latency:**
  - Handshake to `active_ftw`: the first tick after capture, or the second tick if captured on a tick cycle.
  - Handshake to its first effect on `phase_out`: one further tick.
- **`ftw_ready` after a transfer:** it falls the cycle after the transfer, and rises the cycle after the apply.
- **Mid-operation reset:** one `rst` cycle returns every register to its reset value. A pending word is discarded. A source with `ftw_valid` still high sees `ftw_ready` = 1 immediately and transfers on the first edge with `rst` = 0.

## Test plan
All scenarios use ACC_W = 24, PHASE_W = 14, CLK_DIV = 4.

1. **Reset:** hold `rst` 3 cycles with `enable` = 1 and `ftw_valid` = 0 → `phase_out` = 0, `sample_tick` = 0, `wrap` = 0, `ftw_ready` = 1. After release, `sample_tick` pulses every 4 cycles, `phase_out` stays 0, and the first pulse comes 4 edges after release.
2. **Load and run:** send FTW 0x010000 → `ftw_ready` is 0 until the next tick. `phase_out` stays 0 at that tick, then reads 0x0040, 0x0080, 0x00C0 on the following ticks.
3. **Wrap:** FTW 0x400000 → `phase_out` steps 0x1000, 0x2000, 0x3000, 0x0000. `wrap` = 1 only with the tick showing 0x0000.
4. **Back-to-back words:** offer 0x000400 then immediately 0x000800 with `ftw_valid` held → the second word waits while `ftw_ready` = 0. Both words are applied on consecutive ticks, in order, with none lost. Check the same-cycle capture-and-tick case separately.
5. **`phase_sync` on a tick cycle** (FTW 0x010000, `phase_out` = 0x00C0) → the next cycle shows `phase_out` = 0 with no `sample_tick`. The next tick is 4 cycles later and shows 0x0040.
6. **`enable` and mid-run reset:** hold `enable` = 0 for 10 cycles → no ticks and `phase_out` frozen. Then assert `rst` for 1 cycle with a word pending → all outputs return to their reset values and the pending word is dropped.
